except_ctrl: RTL and testbench
==============================

// Module: except_ctrl
// PURPOSE
//  Exception/interrupt arbiter driving the CP0 commit interface. Sits at MEM->WB: takes per-instruction fault
//  flags and CP0 status, picks one event, pulses wb_except/eret_flush toward CP0, flushes the pipeline and
//  holds a PC redirect until fetch accepts it. Precise: only the faulting MEM instruction and younger are killed.
// PARAMETERS
//  EXC_VECTOR  32'hBFC0_0380  exception entry PC (BEV=1 vector)
//  CNT_W       32             width of event counters (EXC_STATS_EN only)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  resetn         in   1   asynchronous, active-low reset
//  mem_valid      in   1   MEM-stage instruction valid
//  mem_ready      out  1   1 = block accepts MEM instruction this cycle (stall when 0)
//  mem_pc         in   32  PC of MEM instruction
//  mem_bd         in   1   MEM instruction is in a delay slot
//  mem_exc        in   7   {adel_if, ri, ov, sys, bp, adel_ld, ades}
//  mem_eret       in   1   MEM instruction is ERET
//  mem_badvaddr   in   32  data address of MEM load/store
//  c0_status_ie   in   1   Status.IE
//  c0_status_exl  in   1   Status.EXL
//  c0_status_im   in   8   Status.IM
//  c0_cause_ip    in   8   Cause.IP
//  c0_epc         in   32  EPC
//  wb_except      out  1   exception commit pulse to CP0
//  eret_flush     out  1   ERET commit pulse to CP0
//  wb_excode      out  5   ExcCode
//  wb_bd          out  1   delay-slot flag of faulting instruction
//  wb_pc          out  32  PC of faulting instruction (CP0 subtracts 4 when wb_bd)
//  wb_badvaddr    out  32  faulting address
//  flush          out  1   kill IF..MEM, one-cycle pulse
//  redirect_valid out  1   new fetch PC valid
//  redirect_pc    out  32  new fetch PC
//  fetch_ready    in   1   fetch accepts redirect
// BEHAVIOUR
//  - Reset: state IDLE; every output 0 except mem_ready=1; int_q=0. Reset mid-FLUSH/REDIRECT aborts to IDLE.
//  - int_q <= ie & ~exl & |(ip & im), registered every cycle; cleared on IDLE->FLUSH transition.
//  - IDLE: mem_ready=1. If mem_valid & (int_q | |mem_exc | mem_eret): capture pc/bd/code/badvaddr -> FLUSH.
//  - Priority: Int(0x00) > AdEL-if(0x04) > RI(0x0a) > Ov(0x0c) > Sys(0x08) > Bp(0x09) > AdEL-ld(0x04) > AdES(0x05).
//  - Exception (incl. int) beats mem_eret on same instruction; eret only when no exception/int.
//  - wb_badvaddr = mem_pc for AdEL-if, mem_badvaddr for AdEL-ld/AdES, else 0.
//  - FLUSH (exactly 1 cycle): flush=1, wb_except=1 xor eret_flush=1, wb_* from capture; mem_ready=0.
//    redirect_pc loaded: EXC_VECTOR, or c0_epc sampled this cycle for eret. -> REDIRECT.
//  - REDIRECT: redirect_valid=1, redirect_pc stable, mem_ready=0 until fetch_ready; on fetch_ready -> IDLE
//    (redirect_valid falls next cycle). Min event latency capture->IDLE: 3 cycles.
//  - wb_except/eret_flush/flush never high outside FLUSH; wb_* fields zero outside FLUSH.
//  - mem_valid & no event in IDLE: pass-through, no state change.
// CONFIGURATION
//  EXC_STATS_EN defined: adds outputs exc_cnt[CNT_W-1:0], eret_cnt[CNT_W-1:0]; +1 per FLUSH of that kind,
//   wrap at 2^CNT_W, reset to 0. Undefined: ports and counters absent, behaviour otherwise identical.
// TESTING
//  1. mem_exc=ov, pc=0xBFC0_1000, bd=0 -> FLUSH: wb_except=1, excode=0x0c, wb_pc=0xBFC0_1000; redirect 0xBFC0_0380.
//  2. mem_exc={ri,sys} both set -> excode=0x0a only; one wb_except pulse.
//  3. adel_ld, badvaddr=0x8000_0003, bd=1 -> excode=0x04, wb_bd=1, wb_badvaddr=0x8000_0003.
//  4. ie=1,exl=0,im=0x80,ip=0x80 one cycle before valid instr -> excode=0x00; with exl=1 -> no event.
//  5. mem_eret, c0_epc=0xBFC0_2000 -> eret_flush=1, wb_except=0, redirect_pc=0xBFC0_2000.
//  6. fetch_ready low 5 cycles -> redirect held, mem_ready=0; resetn low mid-REDIRECT -> all outputs 0 async.

Source files
------------

// File: rtl/except_ctrl.sv
// except_ctrl: exception/interrupt arbiter at the MEM->WB boundary.
// Picks one event per faulting MEM instruction, pulses the CP0 commit strobes,
// flushes IF..MEM for one cycle and holds a fetch redirect until accepted.
// Optional build macro EXC_STATS_EN adds exc_cnt/eret_cnt event counters.
module except_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter int unsigned CNT_W      = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_pc,
   input  logic        mem_bd,
   input  logic [6:0]  mem_exc,
   input  logic        mem_eret,
   input  logic [31:0] mem_badvaddr,
   input  logic        c0_status_ie,
   input  logic        c0_status_exl,
   input  logic [7:0]  c0_status_im,
   input  logic [7:0]  c0_cause_ip,
   input  logic [31:0] c0_epc,
   output logic        wb_except,
   output logic        eret_flush,
   output logic [4:0]  wb_excode,
   output logic        wb_bd,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_badvaddr,
   output logic        flush,
`ifdef EXC_STATS_EN
   output logic [CNT_W-1:0] exc_cnt,
   output logic [CNT_W-1:0] eret_cnt,
`endif
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        fetch_ready
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   state_t      state_r, state_nxt_s;
   logic        int_q_r;
   logic        event_s, is_exc_s, capture_s;
   logic        mem_ready_r, wb_except_r, eret_flush_r, wb_bd_r, flush_r, redirect_valid_r;
   logic [4:0]  wb_excode_r;
   logic [31:0] wb_pc_r, wb_badvaddr_r, redirect_pc_r;

   // ExcCode by fixed priority; a pending interrupt outranks every fault bit
   function automatic logic [4:0] excode_f(input logic irq, input logic [6:0] exc);
      logic [4:0] code;
      if (irq)         code = 5'h00;
      else if (exc[6]) code = 5'h04;
      else if (exc[5]) code = 5'h0a;
      else if (exc[4]) code = 5'h0c;
      else if (exc[3]) code = 5'h08;
      else if (exc[2]) code = 5'h09;
      else if (exc[1]) code = 5'h04;
      else if (exc[0]) code = 5'h05;
      else             code = 5'h00;
      return code;
   endfunction

   // BadVAddr follows the winning cause: fetch PC, data address, or nothing
   function automatic logic [31:0] badvaddr_f(input logic irq, input logic [6:0] exc,
                                               input logic [31:0] pc, input logic [31:0] addr);
      logic [31:0] bva;
      if (irq)                       bva = 32'h0000_0000;
      else if (exc[6])               bva = pc;
      else if (exc[5:2] != 4'b0000)  bva = 32'h0000_0000;
      else if (exc[1] | exc[0])      bva = addr;
      else                           bva = 32'h0000_0000;
      return bva;
   endfunction

   if (CNT_W < 1) begin : g_cnt_w_check
      $error("except_ctrl: CNT_W must be at least 1");
   end

   assign is_exc_s  = int_q_r | (|mem_exc);
   assign event_s   = mem_valid & (is_exc_s | mem_eret);
   assign capture_s = (state_r == ST_IDLE) & event_s;

   // state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_r <= ST_IDLE;
      else         state_r <= state_nxt_s;
   end

   // next-state: capture in IDLE, one FLUSH cycle, hold REDIRECT until fetch takes it
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (event_s) state_nxt_s = ST_FLUSH;
            else         state_nxt_s = ST_IDLE;
         end
         ST_FLUSH:    state_nxt_s = ST_REDIRECT;
         ST_REDIRECT: begin
            if (fetch_ready) state_nxt_s = ST_IDLE;
            else             state_nxt_s = ST_REDIRECT;
         end
         default:     state_nxt_s = ST_IDLE;
      endcase
   end

   // interrupt request sampled every cycle; consumed when an event is captured
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)        int_q_r <= 1'b0;
      else if (capture_s) int_q_r <= 1'b0;
      else                int_q_r <= c0_status_ie & ~c0_status_exl & (|(c0_cause_ip & c0_status_im));
   end

   // registered handshake and commit fields; commit fields live only in the FLUSH cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_ready_r      <= 1'b1;
         flush_r          <= 1'b0;
         redirect_valid_r <= 1'b0;
         wb_except_r      <= 1'b0;
         eret_flush_r     <= 1'b0;
         wb_excode_r      <= 5'h00;
         wb_bd_r          <= 1'b0;
         wb_pc_r          <= 32'h0000_0000;
         wb_badvaddr_r    <= 32'h0000_0000;
      end else begin
         mem_ready_r      <= (state_nxt_s == ST_IDLE);
         flush_r          <= (state_nxt_s == ST_FLUSH);
         redirect_valid_r <= (state_nxt_s == ST_REDIRECT);
         if (capture_s) begin
            wb_except_r   <= is_exc_s;
            eret_flush_r  <= ~is_exc_s;
            wb_excode_r   <= excode_f(int_q_r, mem_exc);
            wb_bd_r       <= mem_bd;
            wb_pc_r       <= mem_pc;
            wb_badvaddr_r <= badvaddr_f(int_q_r, mem_exc, mem_pc, mem_badvaddr);
         end else begin
            wb_except_r   <= 1'b0;
            eret_flush_r  <= 1'b0;
            wb_excode_r   <= 5'h00;
            wb_bd_r       <= 1'b0;
            wb_pc_r       <= 32'h0000_0000;
            wb_badvaddr_r <= 32'h0000_0000;
         end
      end
   end

   // redirect target: EPC (sampled in FLUSH) for ERET, else exception vector; held while pending
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         redirect_pc_r <= 32'h0000_0000;
      end else if (state_r == ST_FLUSH) begin
         if (eret_flush_r) redirect_pc_r <= c0_epc;
         else              redirect_pc_r <= EXC_VECTOR;
      end else if ((state_r == ST_REDIRECT) && !fetch_ready) begin
         redirect_pc_r <= redirect_pc_r;
      end else begin
         redirect_pc_r <= 32'h0000_0000;
      end
   end

`ifdef EXC_STATS_EN
   logic [CNT_W-1:0] exc_cnt_r, eret_cnt_r;

   // per-kind commit counters, wrapping naturally at 2^CNT_W
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         exc_cnt_r  <= '0;
         eret_cnt_r <= '0;
      end else if (state_r == ST_FLUSH) begin
         if (wb_except_r) exc_cnt_r  <= exc_cnt_r + CNT_W'(1);
         else             exc_cnt_r  <= exc_cnt_r;
         if (eret_flush_r) eret_cnt_r <= eret_cnt_r + CNT_W'(1);
         else              eret_cnt_r <= eret_cnt_r;
      end else begin
         exc_cnt_r  <= exc_cnt_r;
         eret_cnt_r <= eret_cnt_r;
      end
   end

   assign exc_cnt  = exc_cnt_r;
   assign eret_cnt = eret_cnt_r;
`endif

   assign mem_ready      = mem_ready_r;
   assign wb_except      = wb_except_r;
   assign eret_flush     = eret_flush_r;
   assign wb_excode      = wb_excode_r;
   assign wb_bd          = wb_bd_r;
   assign wb_pc          = wb_pc_r;
   assign wb_badvaddr    = wb_badvaddr_r;
   assign flush          = flush_r;
   assign redirect_valid = redirect_valid_r;
   assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed self-checking bench for except_ctrl. Inputs change on the falling
// edge; outputs are sampled on the falling edge, half a cycle from the active edge.
module tb_except_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_valid, mem_ready, mem_bd, mem_eret;
   logic [31:0] mem_pc, mem_badvaddr;
   logic [6:0]  mem_exc;
   logic        c0_status_ie, c0_status_exl;
   logic [7:0]  c0_status_im, c0_cause_ip;
   logic [31:0] c0_epc;
   logic        wb_except, eret_flush, wb_bd, flush, redirect_valid, fetch_ready;
   logic [4:0]  wb_excode;
   logic [31:0] wb_pc, wb_badvaddr, redirect_pc;
`ifdef EXC_STATS_EN
   logic [31:0] exc_cnt, eret_cnt;
`endif

   int total = 0;
   int bad   = 0;

   except_ctrl dut (
      .clk(clk), .resetn(resetn),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_pc(mem_pc), .mem_bd(mem_bd),
      .mem_exc(mem_exc), .mem_eret(mem_eret), .mem_badvaddr(mem_badvaddr),
      .c0_status_ie(c0_status_ie), .c0_status_exl(c0_status_exl),
      .c0_status_im(c0_status_im), .c0_cause_ip(c0_cause_ip), .c0_epc(c0_epc),
      .wb_except(wb_except), .eret_flush(eret_flush), .wb_excode(wb_excode),
      .wb_bd(wb_bd), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .flush(flush),
`ifdef EXC_STATS_EN
      .exc_cnt(exc_cnt), .eret_cnt(eret_cnt),
`endif
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_ready(fetch_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // present one MEM instruction for one cycle; returns at the falling edge of the FLUSH cycle
   task automatic issue(input logic [31:0] pc, input logic bd, input logic [6:0] exc,
                        input logic eret, input logic [31:0] bva);
      mem_valid = 1'b1; mem_pc = pc; mem_bd = bd; mem_exc = exc; mem_eret = eret; mem_badvaddr = bva;
      @(posedge clk); #1;
      mem_valid = 1'b0; mem_pc = 32'h0; mem_bd = 1'b0; mem_exc = 7'h00; mem_eret = 1'b0; mem_badvaddr = 32'h0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      #12;
      total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL rst_mem_ready got=%b exp=1", mem_ready); end
      total++; if ({wb_except, eret_flush, flush, redirect_valid, wb_bd} !== 5'b00000) begin
         bad++; $display("FAIL rst_flags got=%b exp=00000", {wb_except, eret_flush, flush, redirect_valid, wb_bd}); end
      total++; if ({wb_excode, wb_pc, wb_badvaddr, redirect_pc} !== 101'h0) begin
         bad++; $display("FAIL rst_fields got=%h exp=0", {wb_excode, wb_pc, wb_badvaddr, redirect_pc}); end
      @(negedge clk); resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_overflow;
      issue(32'hBFC0_1000, 1'b0, 7'b001_0000, 1'b0, 32'h0000_1234);
      total++; if ({flush, wb_except, eret_flush, mem_ready} !== 4'b1100) begin
         bad++; $display("FAIL ov_flush_flags got=%b exp=1100", {flush, wb_except, eret_flush, mem_ready}); end
      total++; if (wb_excode !== 5'h0c) begin bad++; $display("FAIL ov_excode got=%h exp=0c", wb_excode); end
      total++; if (wb_pc !== 32'hBFC0_1000) begin bad++; $display("FAIL ov_pc got=%h exp=bfc01000", wb_pc); end
      total++; if ({wb_bd, wb_badvaddr} !== 33'h0) begin bad++; $display("FAIL ov_bd_bva got=%h exp=0", {wb_bd, wb_badvaddr}); end
      @(negedge clk);
      total++; if ({redirect_valid, flush, wb_except, mem_ready} !== 4'b1000) begin
         bad++; $display("FAIL ov_redir_flags got=%b exp=1000", {redirect_valid, flush, wb_except, mem_ready}); end
      total++; if (redirect_pc !== 32'hBFC0_0380) begin bad++; $display("FAIL ov_redir_pc got=%h exp=bfc00380", redirect_pc); end
      total++; if (wb_pc !== 32'h0) begin bad++; $display("FAIL ov_wbpc_zero got=%h exp=0", wb_pc); end
      @(negedge clk);
      total++; if ({redirect_valid, mem_ready} !== 2'b01) begin
         bad++; $display("FAIL ov_idle got=%b exp=01", {redirect_valid, mem_ready}); end
   endtask

   task automatic test_priority;
      // RI and Sys together: RI wins, single pulse
      issue(32'hBFC0_1100, 1'b0, 7'b010_1000, 1'b0, 32'h0);
      total++; if ({wb_except, wb_excode} !== 6'b1_01010) begin
         bad++; $display("FAIL pri_ri_sys got=%b exp=101010", {wb_except, wb_excode}); end
      @(negedge clk);
      total++; if (wb_except !== 1'b0) begin bad++; $display("FAIL pri_single_pulse got=%b exp=0", wb_except); end
      @(negedge clk);
      // AdEL-if outranks AdES; badvaddr is the fetch PC
      issue(32'hBFC0_0006, 1'b0, 7'b100_0001, 1'b0, 32'h1111_2222);
      total++; if (wb_excode !== 5'h04) begin bad++; $display("FAIL pri_adelif_code got=%h exp=04", wb_excode); end
      total++; if (wb_badvaddr !== 32'hBFC0_0006) begin bad++; $display("FAIL pri_adelif_bva got=%h exp=bfc00006", wb_badvaddr); end
      @(negedge clk); @(negedge clk);
      // Bp alone
      issue(32'hBFC0_1200, 1'b0, 7'b000_0100, 1'b0, 32'h0);
      total++; if (wb_excode !== 5'h09) begin bad++; $display("FAIL pri_bp got=%h exp=09", wb_excode); end
      @(negedge clk); @(negedge clk);
      // exception beats ERET on the same instruction
      c0_epc = 32'hBFC0_7000;
      issue(32'hBFC0_1300, 1'b0, 7'b000_1000, 1'b1, 32'h0);
      total++; if ({wb_except, eret_flush, wb_excode} !== 7'b10_01000) begin
         bad++; $display("FAIL pri_exc_vs_eret got=%b exp=1001000", {wb_except, eret_flush, wb_excode}); end
      @(negedge clk);
      total++; if (redirect_pc !== 32'hBFC0_0380) begin bad++; $display("FAIL pri_exc_vs_eret_pc got=%h exp=bfc00380", redirect_pc); end
      @(negedge clk);
   endtask

   task automatic test_adel_ld;
      issue(32'hBFC0_1400, 1'b1, 7'b000_0010, 1'b0, 32'h8000_0003);
      total++; if ({wb_excode, wb_bd} !== 6'b00100_1) begin
         bad++; $display("FAIL adel_ld_code_bd got=%b exp=001001", {wb_excode, wb_bd}); end
      total++; if (wb_badvaddr !== 32'h8000_0003) begin bad++; $display("FAIL adel_ld_bva got=%h exp=80000003", wb_badvaddr); end
      @(negedge clk); @(negedge clk);
      issue(32'hBFC0_1500, 1'b0, 7'b000_0001, 1'b0, 32'h8000_0011);
      total++; if ({wb_excode, wb_badvaddr} !== {5'h05, 32'h8000_0011}) begin
         bad++; $display("FAIL ades got=%h exp=%h", {wb_excode, wb_badvaddr}, {5'h05, 32'h8000_0011}); end
      @(negedge clk); @(negedge clk);
   endtask

   task automatic test_interrupt;
      c0_status_ie = 1'b1; c0_status_exl = 1'b0; c0_status_im = 8'h80; c0_cause_ip = 8'h80;
      @(negedge clk);
      issue(32'hBFC0_1600, 1'b0, 7'b001_0000, 1'b0, 32'h0);
      c0_cause_ip = 8'h00;
      total++; if ({wb_except, wb_excode, wb_badvaddr} !== {1'b1, 5'h00, 32'h0}) begin
         bad++; $display("FAIL int_code got=%h exp=%h", {wb_except, wb_excode, wb_badvaddr}, {1'b1, 5'h00, 32'h0}); end
      @(negedge clk); @(negedge clk);
      // masked by EXL: instruction passes through
      c0_status_exl = 1'b1; c0_cause_ip = 8'h80;
      @(negedge clk);
      mem_valid = 1'b1; mem_pc = 32'hBFC0_1700;
      @(negedge clk);
      mem_valid = 1'b0;
      total++; if ({flush, wb_except, mem_ready} !== 3'b001) begin
         bad++; $display("FAIL int_exl_masked got=%b exp=001", {flush, wb_except, mem_ready}); end
      @(negedge clk);
      total++; if ({flush, redirect_valid, mem_ready} !== 3'b001) begin
         bad++; $display("FAIL int_exl_idle got=%b exp=001", {flush, redirect_valid, mem_ready}); end
      c0_status_ie = 1'b0; c0_status_exl = 1'b0; c0_status_im = 8'h00; c0_cause_ip = 8'h00;
      @(negedge clk);
   endtask

   task automatic test_eret;
      c0_epc = 32'hBFC0_2000;
      issue(32'hBFC0_1800, 1'b0, 7'b000_0000, 1'b1, 32'h0);
      total++; if ({flush, eret_flush, wb_except} !== 3'b110) begin
         bad++; $display("FAIL eret_flags got=%b exp=110", {flush, eret_flush, wb_except}); end
      @(negedge clk);
      total++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'hBFC0_2000}) begin
         bad++; $display("FAIL eret_redirect got=%h exp=%h", {redirect_valid, redirect_pc}, {1'b1, 32'hBFC0_2000}); end
      total++; if (eret_flush !== 1'b0) begin bad++; $display("FAIL eret_pulse got=%b exp=0", eret_flush); end
      @(negedge clk);
   endtask

   task automatic test_passthrough;
      mem_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_pc = 32'hBFC0_3000 + 32'(i * 4);
         @(negedge clk);
         total++; if ({mem_ready, flush, wb_except, eret_flush} !== 4'b1000) begin
            bad++; $display("FAIL pass_%0d got=%b exp=1000", i, {mem_ready, flush, wb_except, eret_flush}); end
      end
      mem_valid = 1'b0;
   endtask

   task automatic test_back_to_back_hold;
      fetch_ready = 1'b0;
      issue(32'hBFC0_4000, 1'b0, 7'b000_1000, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if ({redirect_valid, mem_ready, redirect_pc} !== {2'b10, 32'hBFC0_0380}) begin
            bad++; $display("FAIL hold_%0d got=%h exp=%h", i, {redirect_valid, mem_ready, redirect_pc}, {2'b10, 32'hBFC0_0380}); end
      end
      fetch_ready = 1'b1;
      @(negedge clk);
      total++; if ({redirect_valid, mem_ready} !== 2'b01) begin
         bad++; $display("FAIL hold_release got=%b exp=01", {redirect_valid, mem_ready}); end
      // reset asserted while the redirect is pending
      fetch_ready = 1'b0;
      issue(32'hBFC0_4100, 1'b0, 7'b000_0100, 1'b0, 32'h0);
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      total++; if ({redirect_valid, flush, wb_except, eret_flush, redirect_pc} !== 36'h0) begin
         bad++; $display("FAIL async_rst got=%h exp=0", {redirect_valid, flush, wb_except, eret_flush, redirect_pc}); end
      total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL async_rst_ready got=%b exp=1", mem_ready); end
      @(negedge clk); resetn = 1'b1; fetch_ready = 1'b1;
      @(negedge clk);
      total++; if ({redirect_valid, mem_ready, flush} !== 3'b010) begin
         bad++; $display("FAIL post_rst_idle got=%b exp=010", {redirect_valid, mem_ready, flush}); end
   endtask

   initial begin
      mem_valid = 1'b0; mem_pc = 32'h0; mem_bd = 1'b0; mem_exc = 7'h00; mem_eret = 1'b0;
      mem_badvaddr = 32'h0; c0_status_ie = 1'b0; c0_status_exl = 1'b0; c0_status_im = 8'h00;
      c0_cause_ip = 8'h00; c0_epc = 32'h0; fetch_ready = 1'b1;
      test_reset();
      test_overflow();
      test_priority();
      test_adel_ld();
      test_interrupt();
      test_eret();
      test_passthrough();
      test_back_to_back_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
